// File: rtl/act_quant_collect.sv
// Collects an LSB-first serial accumulator word, keeps an 8-bit window starting at
// CATCH_START_BIT, and emits a saturated unsigned activation through a one-deep skid buffer.
module act_quant_collect #(
  parameter int CATCH_START_BIT = 10,
  parameter int FRAME_BITS      = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       frame_start,
  output logic       bit_ready,
  output logic [7:0] q_data,
  output logic       q_sat,
  output logic       q_valid,
  input  logic       q_ready
);
  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

  state_t     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [7:0] win_q, win_d;
  logic       hi_q, hi_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic       hold_sat_q, hold_sat_d;
  logic [7:0] q_data_q, q_data_d;
  logic       q_sat_q, q_sat_d;
  logic       q_valid_q, q_valid_d;

  logic       acc, drain, restart, frame_end;
  logic [4:0] cur_idx;
  logic [2:0] widx;
  logic [7:0] win_base, res_data;
  logic       hi_base, res_sat;

  assign bit_ready = !rst && (state_q != FULL);
  assign acc       = bit_valid && bit_ready;
  assign drain     = q_valid_q && q_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    win_d       = win_q;
    hi_d        = hi_q;
    hold_data_d = hold_data_q;
    hold_sat_d  = hold_sat_q;
    q_data_d    = q_data_q;
    q_sat_d     = q_sat_q;
    q_valid_d   = q_valid_q && !q_ready;
    frame_end   = 1'b0;
    res_data    = 8'h00;
    res_sat     = 1'b0;
    widx        = 3'd0;

    // A frame_start bit always begins a fresh frame at index 0, whatever came before.
    restart  = acc && frame_start;
    cur_idx  = restart ? 5'd0 : idx_q;
    win_base = restart ? 8'h00 : win_q;
    hi_base  = restart ? 1'b0 : hi_q;

    if (acc && (restart || state_q == COLLECT)) begin
      win_d = win_base;
      hi_d  = hi_base;
      if (int'(cur_idx) == FRAME_BITS - 1) begin
        frame_end = 1'b1;
      end else begin
        if (int'(cur_idx) >= CATCH_START_BIT && int'(cur_idx) < CATCH_START_BIT + 8) begin
          widx        = 3'(int'(cur_idx) - CATCH_START_BIT);
          win_d[widx] = bit_in;
        end else if (int'(cur_idx) >= CATCH_START_BIT + 8) begin
          hi_d = hi_base | bit_in;
        end
        idx_d   = cur_idx + 5'd1;
        state_d = COLLECT;
      end
    end

    if (frame_end) begin
      if (bit_in) begin
        res_data = 8'h00;
        res_sat  = 1'b1;
      end else if (hi_base) begin
        res_data = 8'hFF;
        res_sat  = 1'b1;
      end else begin
        res_data = win_base;
      end
      idx_d = 5'd0;
      win_d = 8'h00;
      hi_d  = 1'b0;
      if (!q_valid_q || q_ready) begin
        q_data_d  = res_data;
        q_sat_d   = res_sat;
        q_valid_d = 1'b1;
        state_d   = IDLE;
      end else begin
        hold_data_d = res_data;
        hold_sat_d  = res_sat;
        state_d     = FULL;
      end
    end

    if (state_q == FULL && drain) begin
      q_data_d  = hold_data_q;
      q_sat_d   = hold_sat_q;
      q_valid_d = 1'b1;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 5'd0;
      win_q       <= 8'h00;
      hi_q        <= 1'b0;
      hold_data_q <= 8'h00;
      hold_sat_q  <= 1'b0;
      q_data_q    <= 8'h00;
      q_sat_q     <= 1'b0;
      q_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      win_q       <= win_d;
      hi_q        <= hi_d;
      hold_data_q <= hold_data_d;
      hold_sat_q  <= hold_sat_d;
      q_data_q    <= q_data_d;
      q_sat_q     <= q_sat_d;
      q_valid_q   <= q_valid_d;
    end
  end

  assign q_data  = q_data_q;
  assign q_sat   = q_sat_q;
  assign q_valid = q_valid_q;
endmodule
